// File: rtl/matmul_tile_scheduler_if.sv
// Host, core and writeback signals of the matmul tile scheduler.
// The scheduler drives the master side; host, core and writeback sit on the slave side.
interface matmul_tile_scheduler_if #(
    parameter int TW = 2,
    parameter int SW = 3
);
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          err;
    logic          core_start;
    logic          core_done;
    logic [TW-1:0] core_ti;
    logic [TW-1:0] core_tj;
    logic [TW-1:0] core_tk;
    logic [SW-1:0] core_rows;
    logic [SW-1:0] core_cols;
    logic [SW-1:0] core_depth;
    logic          core_first;
    logic          core_last;
    logic          wb_valid;
    logic          wb_ready;

    modport master (
        input  start, abort, core_done, wb_ready,
        output busy, done, err, core_start,
        output core_ti, core_tj, core_tk,
        output core_rows, core_cols, core_depth,
        output core_first, core_last, wb_valid
    );

    modport slave (
        output start, abort, core_done, wb_ready,
        input  busy, done, err, core_start,
        input  core_ti, core_tj, core_tk,
        input  core_rows, core_cols, core_depth,
        input  core_first, core_last, wb_valid
    );
endinterface

// File: rtl/matmul_tile_scheduler.sv
// Walks the (ti,tj,tk) tile space of an N x N matmul through one M x M core,
// tk innermost, handing each finished C tile to writeback.
module matmul_tile_scheduler #(
    parameter int N       = 10,
    parameter int M       = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    matmul_tile_scheduler_if.master   bus
);
    localparam int T  = (N + M - 1) / M;
    localparam int TW = (T > 1) ? $clog2(T) : 1;
    localparam int SW = $clog2(M + 1);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(T - 1);
    localparam logic [SW-1:0] S_FULL = SW'(M);
    localparam logic [SW-1:0] S_EDGE = SW'(N - (T - 1) * M);
    localparam logic [CW-1:0] C_TRIP = CW'(TIMEOUT - 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]    state;
    logic [TW-1:0] ti, tj, tk;
    logic [CW-1:0] cnt;
    logic          err_q;
    logic          busy_w;

    assign busy_w = (state == S_ISSUE) || (state == S_WAIT) ||
                    (state == S_WB)    || (state == S_NEXT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            ti    <= '0;
            tj    <= '0;
            tk    <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (bus.abort && busy_w) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (bus.start) begin
                        state <= S_ISSUE;
                        ti    <= '0;
                        tj    <= '0;
                        tk    <= '0;
                        err_q <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // The trip fires in the cycle the counter would reach TIMEOUT-1; core_done still wins.
                    if (bus.core_done) begin
                        state <= (tk == T_LAST) ? S_WB : S_NEXT;
                    end else if (cnt == C_TRIP) begin
                        state <= S_ERR;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    tk    <= tk + 1'b1;
                    state <= S_ISSUE;
                end
                S_WB: begin
                    if (bus.wb_ready) begin
                        tk <= '0;
                        if (tj == T_LAST) begin
                            tj <= '0;
                            if (ti == T_LAST) begin
                                ti    <= '0;
                                state <= S_FIN;
                            end else begin
                                ti    <= ti + 1'b1;
                                state <= S_ISSUE;
                            end
                        end else begin
                            tj    <= tj + 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_w;
    assign bus.done       = (state == S_FIN);
    assign bus.err        = err_q;
    assign bus.core_start = (state == S_ISSUE);
    assign bus.wb_valid   = (state == S_WB);
    assign bus.core_ti    = ti;
    assign bus.core_tj    = tj;
    assign bus.core_tk    = tk;

    // Extent and accumulator flags are only meaningful during a run, so they read 0 while idle.
    assign bus.core_rows  = !busy_w ? '0 : ((ti == T_LAST) ? S_EDGE : S_FULL);
    assign bus.core_cols  = !busy_w ? '0 : ((tj == T_LAST) ? S_EDGE : S_FULL);
    assign bus.core_depth = !busy_w ? '0 : ((tk == T_LAST) ? S_EDGE : S_FULL);
    assign bus.core_first = busy_w && (tk == '0);
    assign bus.core_last  = busy_w && (tk == T_LAST);
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Randomized bench for matmul_tile_scheduler: a tile-order scoreboard plus
// latency, stall, timeout, abort and reset scenarios on N=10, M=4.
module tb_matmul_tile_scheduler;
    localparam int N  = 10;
    localparam int M  = 4;
    localparam int TO = 8;
    localparam int T  = (N + M - 1) / M;
    localparam int TW = 2;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    matmul_tile_scheduler_if #(.TW(TW), .SW(SW)) bus ();

    matmul_tile_scheduler #(.N(N), .M(M), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ext(input int t);
        return (t * M + M <= N) ? M : N - t * M;
    endfunction

    function automatic logic [31:0] outs();
        return {10'd0, bus.busy, bus.done, bus.err, bus.core_start, bus.core_first,
                bus.core_last, bus.wb_valid, bus.core_ti, bus.core_tj, bus.core_tk,
                bus.core_rows, bus.core_cols, bus.core_depth};
    endfunction

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.core_done = 1'b0;
        bus.wb_ready  = 1'b0;
    endtask

    // One full run against a queue of expected tile triples and C tiles.
    task automatic run_job(input int lat_max, input int rdy_pct, input int stall11, input bit rst_in_wb);
        int exp_t[$];
        int exp_wb[$];
        int pend = 0, lat = 0, last_start = 0, cyc = 0, stalls = 0;
        bit fin = 1'b0;
        for (int i = 0; i < T; i++)
            for (int j = 0; j < T; j++) begin
                for (int k = 0; k < T; k++) exp_t.push_back(i * 100 + j * 10 + k);
                exp_wb.push_back(i * 10 + j);
            end
        bus.start = 1'b1;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bus.start     = 1'b0;
            bus.core_done = 1'b0;
            bus.wb_ready  = 1'b0;
            if (bus.busy) check("err_clear", bus.err, 0);
            if (bus.core_start) begin
                int e;
                int oti, otj, otk;
                e   = (exp_t.size() > 0) ? exp_t.pop_front() : -1;
                oti = int'(bus.core_ti);
                otj = int'(bus.core_tj);
                otk = int'(bus.core_tk);
                check("tile", oti * 100 + otj * 10 + otk, e);
                check("rows", bus.core_rows, ext(oti));
                check("cols", bus.core_cols, ext(otj));
                check("depth", bus.core_depth, ext(otk));
                check("first", bus.core_first, (otk == 0));
                check("last", bus.core_last, (otk == T - 1));
                check("start_busy", bus.busy, 1);
                if (otk > 0) check("tk_gap", cyc - last_start, lat + 2);
                lat        = $urandom_range(lat_max, 1);
                pend       = lat;
                last_start = cyc;
                if ($urandom_range(3, 0) == 0) bus.core_done = 1'b1;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) bus.core_done = 1'b1;
            end else if ($urandom_range(3, 0) == 0) begin
                bus.core_done = 1'b1;
            end
            if (bus.wb_valid) begin
                check("wb_tile", int'(bus.core_ti) * 10 + int'(bus.core_tj),
                      (exp_wb.size() > 0) ? exp_wb[0] : -1);
                check("wb_order", exp_t.size(), (exp_wb.size() - 1) * T);
                check("wb_hold", {bus.busy, bus.core_start, bus.done}, 3'b100);
                if (rst_in_wb) begin
                    #2 rst = 1'b0;
                    #1 check("rst_async", outs(), 0);
                    idle_inputs();
                    @(negedge clk);
                    rst = 1'b1;
                    return;
                end
                if (stall11 > 0 && bus.core_ti == 1 && bus.core_tj == 1 && stalls < stall11) begin
                    stalls++;
                end else begin
                    bus.wb_ready = ($urandom_range(99, 0) < rdy_pct);
                end
                if (bus.wb_ready) void'(exp_wb.pop_front());
            end else begin
                bus.wb_ready = $urandom_range(1, 0);
            end
            if (bus.done) begin
                check("done_q", exp_t.size() + exp_wb.size(), 0);
                check("done_busy", bus.busy, 0);
                fin = 1'b1;
            end
        end
        if (!fin) check("job_budget", 0, 1);
        idle_inputs();
        @(negedge clk);
        check("post_done", {bus.done, bus.busy, bus.core_start, bus.wb_valid}, 0);
    endtask

    task automatic run_timeout();
        int c = 0;
        idle_inputs();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("to_issue", bus.core_start, 1);
        while (bus.busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("to_cycles", c, TO);
        check("to_state", {bus.err, bus.busy, bus.done, bus.core_start, bus.wb_valid}, 5'b10000);
        bus.core_done = 1'b1;
        bus.abort     = 1'b1;
        repeat (3) @(negedge clk);
        idle_inputs();
        check("err_hold", {bus.err, bus.busy, bus.done, bus.core_start, bus.wb_valid}, 5'b10000);
    endtask

    task automatic run_abort();
        idle_inputs();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ab_issue", bus.core_start, 1);
        @(negedge clk);
        bus.core_done = 1'b1;
        bus.abort     = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("ab_idle", {bus.busy, bus.done, bus.core_start, bus.wb_valid}, 0);
        bus.core_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ab_quiet", {bus.busy, bus.done, bus.core_start, bus.wb_valid}, 0);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        check("reset_outs", outs(), 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_outs", outs(), 0);

        run_job(1, 100, 0, 1'b0);
        run_job(6, 60, 5, 1'b0);
        run_timeout();
        run_job(3, 70, 0, 1'b0);
        run_abort();
        run_job(4, 50, 0, 1'b1);
        run_job(2, 80, 0, 1'b0);
        for (int r = 0; r < 3; r++)
            run_job($urandom_range(6, 1), $urandom_range(100, 30), 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
